btn_move_ctrl: RTL and testbench

- Input-side conditioner that generates the one-cycle move/drop commands consumed by the stack logic.
- Synchronises and debounces the raw left, right and centre push-buttons.
- Emits single-cycle `left`/`right` pulses, with optional hold-to-repeat, and a single-cycle `drop` pulse.
- Sits between the board buttons and the stack/game logic, all on the game clock.

---
 rtl/btn_move_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_btn_move_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_move_ctrl.sv
// Button conditioner: 2-flop sync + debounce per button, one-cycle left/right/drop commands, pulse DEBOUNCE_CYCLES+2 edges after press.
// Optional hold-to-repeat on left/right when BTN_AUTO_REPEAT_EN is defined; no backpressure (pulses are fire-and-forget).
module btn_move_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 40000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_l,
  input  logic btn_r,
  input  logic btn_c,
  output logic left,
  output logic right,
  output logic drop,
  output logic held_l,
  output logic held_r
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_param
    $error("btn_move_ctrl: illegal parameter value");
  end

  typedef enum logic [1:0] {
    IDLE,
    LEFT_HELD,
    RIGHT_HELD,
    CONFLICT
  } state_t;

  // Channel index: 0 = left, 1 = right, 2 = centre.
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    deb_q, deb_d;
  logic [2:0]    commit, rise;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];

  state_t state_q, state_d;
  logic   left_q, left_d;
  logic   right_q, right_d;
  logic   drop_q;
  logic   nl, nr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= {btn_c, btn_r, btn_l};
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      commit[i] = (sync2_q[i] != deb_q[i]) && (cnt_q[i] == DB_LAST);
      deb_d[i]  = commit[i] ? sync2_q[i] : deb_q[i];
      rise[i]   = commit[i] & sync2_q[i];
      if ((sync2_q[i] == deb_q[i]) || commit[i]) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // The FSM reacts to the levels the debouncer is about to commit, so the
  // command pulse is registered on the same edge the debounced level changes.
  assign nl = deb_d[0];
  assign nr = deb_d[1];

`ifdef BTN_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(RMAX + 1);
  localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);

  logic [TW-1:0] tmr_q, tmr_d;
  logic [TW-1:0] target;
  logic          first_q, first_d;

  assign target = first_q ? DLY_LAST : PER_LAST;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q   <= '0;
      first_q <= 1'b1;
    end else begin
      tmr_q   <= tmr_d;
      first_q <= first_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    left_d  = 1'b0;
    right_d = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
    tmr_d   = '0;
    first_d = first_q;
`endif
    case (state_q)
      IDLE: begin
        if (rise[0] || rise[1]) begin
          if (nl && nr) begin
            state_d = CONFLICT;
          end else if (rise[0]) begin
            state_d = LEFT_HELD;
            left_d  = 1'b1;
          end else begin
            state_d = RIGHT_HELD;
            right_d = 1'b1;
          end
        end
      end
      LEFT_HELD: begin
        if (rise[1]) begin
          state_d = CONFLICT;
        end else if (!nl) begin
          state_d = IDLE;
`ifdef BTN_AUTO_REPEAT_EN
        end else if (tmr_q == target) begin
          left_d  = 1'b1;
          first_d = 1'b0;
        end else begin
          tmr_d = tmr_q + TW'(1);
`endif
        end
      end
      RIGHT_HELD: begin
        if (rise[0]) begin
          state_d = CONFLICT;
        end else if (!nr) begin
          state_d = IDLE;
`ifdef BTN_AUTO_REPEAT_EN
        end else if (tmr_q == target) begin
          right_d = 1'b1;
          first_d = 1'b0;
        end else begin
          tmr_d = tmr_q + TW'(1);
`endif
        end
      end
      CONFLICT: begin
        // Resolve on surviving levels; the survivor is entered silently.
        if (nl && !nr) begin
          state_d = LEFT_HELD;
        end else if (!nl && nr) begin
          state_d = RIGHT_HELD;
        end else if (!nl && !nr) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef BTN_AUTO_REPEAT_EN
    if (state_d != state_q) first_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      right_q <= right_d;
      drop_q  <= rise[2];
    end
  end

  assign left   = left_q;
  assign right  = right_q;
  assign drop   = drop_q;
  assign held_l = deb_q[0];
  assign held_r = deb_q[1];

endmodule

// File: tb/tb_btn_move_ctrl.sv
// Bench for btn_move_ctrl: phase table with pulse counts, reset corner sequences,
// random button activity checked every cycle against a window/schedule reference model.
module tb_btn_move_ctrl;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;
`ifdef BTN_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam int O_NONE = 0;
  localparam int O_L    = 1;
  localparam int O_R    = 2;
  localparam int O_BOTH = 3;

  logic clk = 1'b0;
  logic rst;
  logic btn_l, btn_r, btn_c;
  logic left, right, drop, held_l, held_r;

  always #5 clk = ~clk;

  btn_move_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btn_l (btn_l),
    .btn_r (btn_r),
    .btn_c (btn_c),
    .left  (left),
    .right (right),
    .drop  (drop),
    .held_l(held_l),
    .held_r(held_r)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cnt_l, cnt_r, cnt_c;

  // Reference model: a button's level flips once the last DB synchronised
  // samples all disagree with it; repeats are scheduled at absolute edge numbers.
  bit          m_s1 [3];
  bit          m_s2 [3];
  bit          m_d  [3];
  logic [DB-1:0] m_win [3];
  int          m_fill [3];
  int          m_owner, m_n, m_fire;
  bit          e_l, e_r, e_c;

  function automatic void model_reset();
    for (int ch = 0; ch < 3; ch++) begin
      m_s1[ch] = 1'b0; m_s2[ch] = 1'b0; m_d[ch] = 1'b0;
      m_win[ch] = '0;  m_fill[ch] = 0;
    end
    m_owner = O_NONE; m_n = 0; m_fire = 0;
    e_l = 1'b0; e_r = 1'b0; e_c = 1'b0;
  endfunction

  function automatic void model_step();
    bit nd [3];
    bit rs [3];
    bit nl, nr;
    m_n++;
    for (int ch = 0; ch < 3; ch++) begin
      nd[ch] = m_d[ch];
      m_win[ch] = {m_win[ch][DB-2:0], m_s2[ch]};
      if (m_fill[ch] < DB) m_fill[ch]++;
      if (m_fill[ch] == DB && m_win[ch] == {DB{~m_d[ch]}}) begin
        nd[ch] = m_s2[ch];
        m_fill[ch] = 0;
      end
      rs[ch] = nd[ch] & ~m_d[ch];
    end
    m_s2 = m_s1;
    m_s1[0] = btn_l; m_s1[1] = btn_r; m_s1[2] = btn_c;
    e_l = 1'b0; e_r = 1'b0; e_c = rs[2];
    nl = nd[0]; nr = nd[1];
    case (m_owner)
      O_NONE: if (rs[0] || rs[1]) begin
        if (nl && nr) m_owner = O_BOTH;
        else if (rs[0]) begin m_owner = O_L; e_l = 1'b1; m_fire = m_n + RD; end
        else begin m_owner = O_R; e_r = 1'b1; m_fire = m_n + RD; end
      end
      O_L: begin
        if (rs[1]) m_owner = O_BOTH;
        else if (!nl) m_owner = O_NONE;
        else if (AUTO && m_n == m_fire) begin e_l = 1'b1; m_fire = m_n + RP; end
      end
      O_R: begin
        if (rs[0]) m_owner = O_BOTH;
        else if (!nr) m_owner = O_NONE;
        else if (AUTO && m_n == m_fire) begin e_r = 1'b1; m_fire = m_n + RP; end
      end
      default: begin
        if (nl && !nr) begin m_owner = O_L; m_fire = m_n + RD; end
        else if (!nl && nr) begin m_owner = O_R; m_fire = m_n + RD; end
        else if (!nl && !nr) m_owner = O_NONE;
      end
    endcase
    m_d = nd;
  endfunction

  function automatic logic [31:0] outs();
    return {27'b0, left, right, drop, held_l, held_r};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    check("cycle{l,r,c,hl,hr}", outs(), {27'b0, e_l, e_r, e_c, m_d[0], m_d[1]});
    cnt_l += int'(left);
    cnt_r += int'(right);
    cnt_c += int'(drop);
  endtask

  typedef struct {
    bit l, r, c;
    int n;
    int el, er, ed;
    bit hl, hr;
  } row_t;

  function automatic row_t mk(bit l, bit r, bit c, int n, int el, int er, int ed, bit hl, bit hr);
    row_t x;
    x.l = l; x.r = r; x.c = c; x.n = n;
    x.el = el; x.er = er; x.ed = ed; x.hl = hl; x.hr = hr;
    return x;
  endfunction

  localparam int NR = 18;
  row_t rows [NR];

  initial begin
    rows[0]  = mk(1, 0, 0, 10, 1, 0, 0, 1, 0);             // clean press
    rows[1]  = mk(0, 0, 0, 12, 0, 0, 0, 0, 0);             // release
    rows[2]  = mk(1, 0, 0,  2, 0, 0, 0, 0, 0);             // bounce x3
    rows[3]  = mk(0, 0, 0,  2, 0, 0, 0, 0, 0);
    rows[4]  = mk(1, 0, 0,  2, 0, 0, 0, 0, 0);
    rows[5]  = mk(0, 0, 0,  2, 0, 0, 0, 0, 0);
    rows[6]  = mk(1, 0, 0,  2, 0, 0, 0, 0, 0);
    rows[7]  = mk(0, 0, 0,  2, 0, 0, 0, 0, 0);
    rows[8]  = mk(0, 0, 0,  8, 0, 0, 0, 0, 0);
    rows[9]  = mk(0, 1, 0, 50, 0, AUTO ? 5 : 1, 0, 0, 1);  // hold right, edges 6/26/34/42/50
    rows[10] = mk(0, 0, 0, 12, 0, 0, 0, 0, 0);
    rows[11] = mk(1, 1, 0, 10, 0, 0, 0, 1, 1);             // simultaneous press
    rows[12] = mk(0, 1, 0, 27, 0, AUTO ? 1 : 0, 0, 0, 1);  // left drops out, right 20 after
    rows[13] = mk(0, 0, 0, 12, 0, 0, 0, 0, 0);
    rows[14] = mk(0, 0, 1, 12, 0, 0, 1, 0, 0);             // drop
    rows[15] = mk(0, 0, 0, 12, 0, 0, 0, 0, 0);
    rows[16] = mk(0, 0, 1,  3, 0, 0, 0, 0, 0);             // short glitch
    rows[17] = mk(0, 0, 0,  8, 0, 0, 0, 0, 0);

    rst = 1'b1; btn_l = 1'b0; btn_r = 1'b0; btn_c = 1'b0;
    cnt_l = 0; cnt_r = 0; cnt_c = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NR; i++) begin
      btn_l = rows[i].l; btn_r = rows[i].r; btn_c = rows[i].c;
      cnt_l = 0; cnt_r = 0; cnt_c = 0;
      repeat (rows[i].n) tick();
      check($sformatf("row%0d_left_count", i),  cnt_l, rows[i].el);
      check($sformatf("row%0d_right_count", i), cnt_r, rows[i].er);
      check($sformatf("row%0d_drop_count", i),  cnt_c, rows[i].ed);
      check($sformatf("row%0d_held_l", i), {31'b0, held_l}, {31'b0, rows[i].hl});
      check($sformatf("row%0d_held_r", i), {31'b0, held_r}, {31'b0, rows[i].hr});
    end

    // Asynchronous reset while left is held, then held through reset release.
    btn_l = 1'b1;
    repeat (8) tick();
    check("pre_rst_held_l", {31'b0, held_l}, 32'd1);
    #2 rst = 1'b1;
    model_reset();
    #1 check("async_rst_outputs", outs(), 32'd0);
    repeat (3) tick();
    #2 rst = 1'b0;
    cnt_l = 0;
    repeat (5) tick();
    check("post_rst_no_early_left", cnt_l, 0);
    tick();
    check("post_rst_fresh_left", {31'b0, left}, 32'd1);
    btn_l = 1'b0;
    repeat (12) tick();

    // Drop held for 50 cycles with a reset pulse at cycle 20.
    btn_c = 1'b1;
    cnt_c = 0;
    repeat (19) tick();
    check("drop_once", cnt_c, 1);
    #2 rst = 1'b1;
    model_reset();
    #1 check("drop_async_rst", outs(), 32'd0);
    tick();
    #2 rst = 1'b0;
    cnt_c = 0;
    repeat (5) tick();
    check("drop_after_rst_early", cnt_c, 0);
    tick();
    check("drop_after_rst", {31'b0, drop}, 32'd1);
    cnt_c = 0;
    repeat (25) tick();
    check("drop_no_repeat", cnt_c, 0);
    btn_c = 1'b0;
    repeat (12) tick();

    // Random button activity.
    for (int k = 0; k < 120; k++) begin
      btn_l = ($urandom_range(0, 4) < 2);
      btn_r = ($urandom_range(0, 4) < 2);
      btn_c = ($urandom_range(0, 4) < 2);
      repeat ($urandom_range(1, 35)) tick();
    end
    btn_l = 1'b0; btn_r = 1'b0; btn_c = 1'b0;
    repeat (12) tick();
    check("final_idle", outs(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
